// File: rtl/spu_pkg.sv
// Shared SPU definitions: bubble encodings and the fetch FSM state type.
package spu_pkg;

   localparam logic [31:0] BUBBLE_WORD = 32'hFFFF_FFFF;
   localparam logic [63:0] NOP_PAIR    = {BUBBLE_WORD, BUBBLE_WORD};

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction-pair buffer: each entry holds a fetched pair and its byte address.
// depth must be a power of two (pointers wrap naturally).
module fetch_fifo #(
   parameter int unsigned depth     = 4,
   parameter int unsigned dataWidth = 64,
   parameter int unsigned addrWidth = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [dataWidth-1:0]     push_data,
   input  logic [addrWidth-1:0]     push_addr,
   output logic [dataWidth-1:0]     head_data,
   output logic [addrWidth-1:0]     head_addr,
   output logic [$clog2(depth):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned ptrWidth = $clog2(depth);

   logic [dataWidth-1:0] data_q [depth];
   logic [addrWidth-1:0] addr_q [depth];
   logic [ptrWidth-1:0]  wr_ptr_q, rd_ptr_q;
   logic [ptrWidth:0]    count_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{ptrWidth{1'b0}}, push} - {{ptrWidth{1'b0}}, pop};
      end
   end

   // Storage carries no reset; only entries below count are ever observed.
   always_ff @(posedge clk) begin
      if (push && !clear && !reset) begin
         data_q[wr_ptr_q] <= push_data;
         addr_q[wr_ptr_q] <= push_addr;
      end
   end

   assign head_data = data_q[rd_ptr_q];
   assign head_addr = addr_q[rd_ptr_q];
   assign count     = count_q;
   assign full      = (count_q == (ptrWidth+1)'(depth));
   assign empty     = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc/credit control, redirect/halt FSM and pair buffer.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
   import spu_pkg::*;
#(
   parameter int unsigned pcWidth   = 15,
   parameter int unsigned instWidth = 32,
   parameter int unsigned fifoDepth = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stallIn,
   input  logic                   branchValid,
   input  logic [pcWidth-1:0]     branchTarget,
   input  logic                   haltIn,
   output logic                   memRe,
   output logic [pcWidth-1:0]     memAddr,
   input  logic [2*instWidth-1:0] memData,
   output logic [2*instWidth-1:0] instOut,
   output logic [pcWidth-1:0]     pcOut,
   output logic [31:0]            fetchCount,
   output logic [31:0]            stallCount
);

   localparam int unsigned cntWidth = $clog2(fifoDepth) + 1;

   fetch_state_t state_q, state_d;

   logic [pcWidth-1:0]     pc_q, inflight_addr_q, pc_out_q;
   logic                   inflight_q, bubble_q;
   logic [2*instWidth-1:0] inst_q, incoming;

   logic [cntWidth-1:0]    fifo_count;
   logic [cntWidth:0]      occupancy;
   logic                   fifo_full, fifo_empty;
   logic [2*instWidth-1:0] fifo_head_data;
   logic [pcWidth-1:0]     fifo_head_addr;
   logic                   credit, push_valid, bypass, fifo_push, fifo_pop;
   logic                   unused_target_lsbs;

   assign unused_target_lsbs = ^branchTarget[1:0];

   // Requests already in flight count against the buffer so a push never finds it full.
   assign occupancy = {1'b0, fifo_count} + {{cntWidth{1'b0}}, inflight_q};
   assign credit    = (occupancy < (cntWidth+1)'(fifoDepth)) && !fifo_full;

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (branchValid) begin
         state_d = FLUSH;
      end else begin
         unique case (state_q)
            RUN:     if (haltIn) state_d = HALT;
            FLUSH:   state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      memRe   = !reset && (state_q == RUN) && !branchValid && !haltIn && credit;
      memAddr = pc_q;
   end

   always_comb begin
      incoming = memData;
      if (bubble_q) incoming[instWidth-1:0] = BUBBLE_WORD[instWidth-1:0];
   end

   // An empty buffer is bypassed so a fresh response reaches instOut in the push cycle.
   assign push_valid = inflight_q && !branchValid;
   assign bypass     = push_valid && !stallIn && fifo_empty;
   assign fifo_push  = push_valid && !bypass;
   assign fifo_pop   = !branchValid && !stallIn && !fifo_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q            <= '0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
         bubble_q        <= 1'b0;
         inst_q          <= NOP_PAIR;
         pc_out_q        <= '0;
      end else begin
         inflight_q      <= memRe;
         inflight_addr_q <= pc_q;
         if (branchValid) begin
            pc_q     <= {branchTarget[pcWidth-1:3], 3'b000};
            bubble_q <= branchTarget[2];
            inst_q   <= NOP_PAIR;
         end else begin
            if (memRe)      pc_q     <= pc_q + pcWidth'(8);
            if (push_valid) bubble_q <= 1'b0;
            if (!stallIn) begin
               if (fifo_pop) begin
                  inst_q   <= fifo_head_data;
                  pc_out_q <= fifo_head_addr;
               end else if (bypass) begin
                  inst_q   <= incoming;
                  pc_out_q <= inflight_addr_q;
               end else begin
                  inst_q   <= NOP_PAIR;
               end
            end
         end
      end
   end

   assign instOut = inst_q;
   assign pcOut   = pc_out_q;

   fetch_fifo #(
      .depth     (fifoDepth),
      .dataWidth (2*instWidth),
      .addrWidth (pcWidth)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (branchValid),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data (incoming),
      .push_addr (inflight_addr_q),
      .head_data (fifo_head_data),
      .head_addr (fifo_head_addr),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;
   logic        load_pair;

   assign load_pair = fifo_pop || bypass;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (load_pair) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stallIn)   stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetchCount = fetch_cnt_q;
   assign stallCount = stall_cnt_q;
`else
   assign fetchCount = '0;
   assign stallCount = '0;
`endif

endmodule
